// File: rtl/priority_arbiter_8.sv
// 8-requester arbiter with fixed-priority or round-robin winner selection.
// Each grant is held until release, request drop, or hold timeout, followed by a one-cycle gap.
module priority_arbiter_8 #(
    parameter int RR      = 1,
    parameter int TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic       rel,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_valid,
    output logic       busy,
    output logic       timeout_evt
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    localparam bit          TO_EN     = (TIMEOUT != 0);
    localparam int unsigned TO_LAST_I = (TIMEOUT == 0) ? 0 : (TIMEOUT - 1);
    localparam logic [7:0]  TO_LAST   = TO_LAST_I[7:0];

    // Downward search from start, wrapping 0 -> 7; offset 0 (start itself) has top priority.
    function automatic logic [2:0] pick_winner(input logic [7:0] r, input logic [2:0] start);
        logic [2:0] w;
        logic [2:0] idx;
        w = 3'd0;
        for (int k = 7; k >= 0; k--) begin
            idx = start - 3'(k);
            if (r[idx]) begin
                w = idx;
            end else begin
                w = w;
            end
        end
        return w;
    endfunction

    state_t     state_q, state_d;
    logic [7:0] gnt_q, gnt_d;
    logic [2:0] gnt_idx_q, gnt_idx_d;
    logic       gnt_valid_q, gnt_valid_d;
    logic       busy_q, busy_d;
    logic       timeout_evt_q, timeout_evt_d;
    logic [2:0] ptr_q, ptr_d;
    logic [7:0] hold_cnt_q, hold_cnt_d;

    logic [2:0] search_start_s;
    logic [2:0] winner_s;
    logic       any_req_s;
    logic       cur_req_s;
    logic       timeout_hit_s;
    logic       exit_s;

    // Winner selection and grant-exit conditions.
    always_comb begin
        search_start_s = (RR != 0) ? (ptr_q - 3'd1) : 3'd7;
        winner_s       = pick_winner(req, search_start_s);
        any_req_s      = |req;
        cur_req_s      = req[gnt_idx_q];
        timeout_hit_s  = TO_EN && (hold_cnt_q == TO_LAST);
        exit_s         = rel || !cur_req_s || timeout_hit_s;
    end

    // Next-state and next-output computation.
    always_comb begin
        state_d       = state_q;
        gnt_d         = gnt_q;
        gnt_idx_d     = gnt_idx_q;
        ptr_d         = ptr_q;
        hold_cnt_d    = hold_cnt_q;
        timeout_evt_d = 1'b0;
        case (state_q)
            ST_IDLE, ST_GAP: begin
                if (any_req_s) begin
                    state_d    = ST_GRANT;
                    gnt_d      = 8'd1 << winner_s;
                    gnt_idx_d  = winner_s;
                    hold_cnt_d = 8'd0;
                end else begin
                    state_d    = ST_IDLE;
                    gnt_d      = 8'd0;
                end
            end
            ST_GRANT: begin
                if (exit_s) begin
                    state_d       = ST_GAP;
                    gnt_d         = 8'd0;
                    ptr_d         = (RR != 0) ? gnt_idx_q : ptr_q;
                    // A release or drop in the same cycle as the timeout is a normal release.
                    timeout_evt_d = timeout_hit_s && !rel && cur_req_s;
                end else begin
                    state_d    = ST_GRANT;
                    hold_cnt_d = (hold_cnt_q == 8'hFF) ? hold_cnt_q : (hold_cnt_q + 8'd1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = 8'd0;
            end
        endcase
        gnt_valid_d = (state_d == ST_GRANT);
        busy_d      = (state_d != ST_IDLE);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            gnt_q         <= 8'd0;
            gnt_idx_q     <= 3'd0;
            gnt_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
            timeout_evt_q <= 1'b0;
            ptr_q         <= 3'd0;
            hold_cnt_q    <= 8'd0;
        end else begin
            state_q       <= state_d;
            gnt_q         <= gnt_d;
            gnt_idx_q     <= gnt_idx_d;
            gnt_valid_q   <= gnt_valid_d;
            busy_q        <= busy_d;
            timeout_evt_q <= timeout_evt_d;
            ptr_q         <= ptr_d;
            hold_cnt_q    <= hold_cnt_d;
        end
    end

    assign gnt         = gnt_q;
    assign gnt_idx     = gnt_idx_q;
    assign gnt_valid   = gnt_valid_q;
    assign busy        = busy_q;
    assign timeout_evt = timeout_evt_q;

endmodule

// File: tb/tb_priority_arbiter_8.sv
// Directed bench for priority_arbiter_8: a fixed-priority instance (a) and a round-robin instance (b).
module tb_priority_arbiter_8;

    logic       clk;
    logic       rst_n;
    logic [7:0] req_a, req_b;
    logic       rel_a, rel_b;
    logic [7:0] gnt_a, gnt_b;
    logic [2:0] idx_a, idx_b;
    logic       valid_a, valid_b;
    logic       busy_a, busy_b;
    logic       evt_a, evt_b;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc;
    logic [2:0] e_idx;

    priority_arbiter_8 #(.RR(0), .TIMEOUT(15)) dut_a (
        .clk(clk), .rst_n(rst_n), .req(req_a), .rel(rel_a),
        .gnt(gnt_a), .gnt_idx(idx_a), .gnt_valid(valid_a), .busy(busy_a), .timeout_evt(evt_a)
    );

    priority_arbiter_8 #(.RR(1), .TIMEOUT(15)) dut_b (
        .clk(clk), .rst_n(rst_n), .req(req_b), .rel(rel_b),
        .gnt(gnt_b), .gnt_idx(idx_b), .gnt_valid(valid_b), .busy(busy_b), .timeout_evt(evt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        req_a = 8'h00; rel_a = 1'b0;
        req_b = 8'h00; rel_b = 1'b0;
        repeat (3) tick();
        check_eq("rst_gnt_a",   32'(gnt_a),   32'h0);
        check_eq("rst_idx_a",   32'(idx_a),   32'h0);
        check_eq("rst_valid_a", 32'(valid_a), 32'h0);
        check_eq("rst_busy_a",  32'(busy_a),  32'h0);
        check_eq("rst_evt_b",   32'(evt_b),   32'h0);
        rst_n = 1'b1;

        // Test 1: reset mid-grant
        req_a = 8'h01;
        tick();
        check_eq("t1_gnt",   32'(gnt_a),   32'h01);
        check_eq("t1_valid", 32'(valid_a), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("t1_async_gnt",   32'(gnt_a),   32'h0);
        check_eq("t1_async_valid", 32'(valid_a), 32'h0);
        check_eq("t1_async_busy",  32'(busy_a),  32'h0);
        tick();
        rst_n = 1'b1;
        check_eq("t1_post_rst_gnt", 32'(gnt_a), 32'h0);
        tick();
        check_eq("t1_regrant_gnt", 32'(gnt_a), 32'h01);
        check_eq("t1_regrant_idx", 32'(idx_a), 32'h0);
        req_a = 8'h00;
        tick();
        check_eq("t1_gap_gnt",  32'(gnt_a),  32'h0);
        check_eq("t1_gap_busy", 32'(busy_a), 32'h1);
        tick();
        check_eq("t1_idle_busy", 32'(busy_a), 32'h0);

        // Test 2: fixed priority starves idx2
        req_a = 8'b1000_0100;
        tick();
        for (int g = 0; g < 3; g++) begin
            check_eq("t2_idx", 32'(idx_a), 32'h7);
            check_eq("t2_gnt", 32'(gnt_a), 32'h80);
            rel_a = 1'b1;
            tick();
            rel_a = 1'b0;
            check_eq("t2_gap_gnt",   32'(gnt_a),   32'h0);
            check_eq("t2_gap_valid", 32'(valid_a), 32'h0);
            check_eq("t2_gap_busy",  32'(busy_a),  32'h1);
            tick();
        end
        check_eq("t2_last_idx", 32'(idx_a), 32'h7);
        rel_a = 1'b1;
        req_a = 8'h00;
        tick();
        rel_a = 1'b0;
        tick();
        check_eq("t2_idle_busy", 32'(busy_a), 32'h0);

        // Test 3: round-robin rotation
        req_b = 8'hFF;
        tick();
        for (int i = 0; i < 9; i++) begin
            e_idx = 3'd7 - 3'(i);
            check_eq("t3_idx", 32'(idx_b), 32'(e_idx));
            check_eq("t3_gnt", 32'(gnt_b), 32'(8'd1 << e_idx));
            tick();
            check_eq("t3_hold_idx", 32'(idx_b), 32'(e_idx));
            rel_b = 1'b1;
            tick();
            rel_b = 1'b0;
            check_eq("t3_gap_gnt", 32'(gnt_b), 32'h0);
            tick();
        end
        req_b = 8'h00;
        rel_b = 1'b1;
        tick();
        rel_b = 1'b0;
        tick();
        check_eq("t3_idle_busy", 32'(busy_b), 32'h0);

        // Test 4: hold timeout
        req_b = 8'h10;
        tick();
        cyc = 0;
        while (gnt_b == 8'h10 && cyc < 40) begin
            cyc++;
            tick();
        end
        check_eq("t4_grant_len", 32'(cyc),    32'd15);
        check_eq("t4_evt",       32'(evt_b),  32'h1);
        check_eq("t4_gap_gnt",   32'(gnt_b),  32'h0);
        check_eq("t4_gap_busy",  32'(busy_b), 32'h1);
        tick();
        check_eq("t4_regrant_gnt", 32'(gnt_b), 32'h10);
        check_eq("t4_regrant_idx", 32'(idx_b), 32'h4);
        check_eq("t4_evt_pulse",   32'(evt_b), 32'h0);

        // Test 5: release coincides with timeout
        repeat (14) tick();
        check_eq("t5_c15_gnt", 32'(gnt_b), 32'h10);
        rel_b = 1'b1;
        tick();
        rel_b = 1'b0;
        check_eq("t5_gap_gnt",  32'(gnt_b),  32'h0);
        check_eq("t5_evt",      32'(evt_b),  32'h0);
        check_eq("t5_gap_busy", 32'(busy_b), 32'h1);
        req_b = 8'h00;
        tick();
        check_eq("t5_idle_busy", 32'(busy_b), 32'h0);

        // Test 6: requester drop
        req_a = 8'h08;
        tick();
        check_eq("t6_idx", 32'(idx_a), 32'h3);
        tick();
        check_eq("t6_hold_gnt", 32'(gnt_a), 32'h08);
        req_a = 8'h00;
        tick();
        check_eq("t6_gap_gnt",   32'(gnt_a),   32'h0);
        check_eq("t6_gap_valid", 32'(valid_a), 32'h0);
        check_eq("t6_gap_busy",  32'(busy_a),  32'h1);
        check_eq("t6_gap_evt",   32'(evt_a),   32'h0);
        tick();
        check_eq("t6_idle_busy", 32'(busy_a), 32'h0);
        check_eq("t6_idle_idx",  32'(idx_a),  32'h3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
